chart_recorder: RTL
===================

CHART_RECORDER -- requirements
Module: chart_recorder

Interface
REQ-001 Parameters SHALL be none; widths are fixed: 7-bit address, 4-bit arrows, 4-bit timing, 8-bit entry.
REQ-002 clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  pulse; begins a new recording.
REQ-005 stop_i  input  1  pulse; ends recording and appends terminator.
REQ-006 beat_i  input  1  one-cycle beat tick (tempo source).
REQ-007 buttons_i  input  4  synchronized, debounced pad levels; bit order matches chart arrows.
REQ-008 wr_en_o  output  1  RAM write strobe, one cycle per entry.
REQ-009 wr_addr_o  output  7  RAM write address.
REQ-010 wr_data_o  output  8  entry {arrows[3:0], timing[3:0]}, same packing the chart reader consumes.
REQ-011 busy_o  output  1  high in REC and TERM.
REQ-012 done_o  output  1  high in DONE.
REQ-013 entries_o  output  8  count of entries written including terminator, 0..128.

Function
REQ-014 FSM states SHALL be IDLE, REC, TERM, DONE.
REQ-015 start_i in IDLE or DONE SHALL clear address, arrow mask, gap counter, entries_o and enter REC next cycle; start_i in REC/TERM is ignored.
REQ-016 In REC, a rising edge on buttons_i[n] (vs. previous-cycle register) SHALL set mask[n]; the edge register updates every cycle in all states.
REQ-017 On beat_i in REC, gap_next = gap+1; if mask (including edges of this cycle) is nonzero or gap_next == 15, an entry {mask, gap_next} SHALL be written, mask and gap cleared, address incremented; otherwise gap = gap_next only.
REQ-018 Timing field SHALL therefore be 1..15 for data entries; an empty-mask entry with timing 15 is a rest entry.
REQ-019 Write outputs SHALL be registered: wr_en_o asserts exactly one cycle after the beat_i cycle that triggers the write, with matching wr_addr_o/wr_data_o.
REQ-020 Rising edges in the same cycle as a write-triggering beat SHALL be included in that entry, not carried forward.
REQ-021 After the entry at address 126 is written, the FSM SHALL enter TERM (auto-stop); address 127 is reserved for the terminator.
REQ-022 stop_i in REC SHALL enter TERM; if beat_i coincides, the beat entry is written first (same cycle transition), then the terminator.
REQ-023 TERM SHALL write terminator {4'b0000, 4'b0000} at the current address in one cycle, then enter DONE.
REQ-024 Pending mask/gap at stop SHALL be discarded.
REQ-025 entries_o SHALL increment on every wr_en_o; wr_en_o SHALL never assert in IDLE or DONE.
REQ-026 beat_i and buttons_i outside REC SHALL have no effect on outputs.

Reset
REQ-027 reset_i SHALL force IDLE, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, entries_o=0, mask=0, gap=0, edge register=0, from any state including mid-recording; an in-flight write is dropped.

Structure
REQ-028 Package ddr_pkg SHALL hold the state enum, ADDR_W=7, ARROW_W=4, TIMING_W=4, TIMING_MAX=15, TERMINATOR=8'h00.
REQ-029 The address SHALL be generated by an instance of counter_up (WIDTH_P=7), reset_i driven by reset or start, up_i driven by the write strobe.

Verification
REQ-030 Reset mid-REC at address 5 -> next cycle all outputs 0, state IDLE, no wr_en_o.
REQ-031 start; press btn0 between beat 1 and 2, btn2 before beat 3 -> writes addr0=8'h12, addr1=8'h41.
REQ-032 start; 20 beats, no presses -> addr0=8'h0F at beat 15, no further write until beat 30.
REQ-033 start; btn1 rises on same cycle as beat 1 -> addr0=8'h21, one cycle after that beat.
REQ-034 start; 127 entries written -> terminator 8'h00 at addr 127, done_o=1, entries_o=128, further beats write nothing.
REQ-035 start; press btn3, stop_i coincident with beat 2 -> addr0=8'h82, addr1=8'h00, then DONE, entries_o=2.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the dance-chart recorder.
package ddr_pkg;

  localparam int ADDR_W   = 7;
  localparam int ARROW_W  = 4;
  localparam int TIMING_W = 4;
  localparam int ENTRY_W  = ARROW_W + TIMING_W;

  localparam logic [TIMING_W-1:0] TIMING_MAX     = 4'd15;
  localparam logic [ENTRY_W-1:0]  TERMINATOR     = 8'h00;
  // Highest address that may hold a data entry; the slot after it is the terminator.
  localparam logic [ADDR_W-1:0]   LAST_DATA_ADDR = 7'd126;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    TERM,
    DONE
  } state_t;

  // Entry packing shared with the chart reader: arrows high, timing low.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ARROW_W-1:0] arrows,
                                                    input logic [TIMING_W-1:0] timing);
    return {arrows, timing};
  endfunction

endpackage

// File: rtl/counter_up.sv
// Simple synchronous up-counter with synchronous clear.
module counter_up #(
  parameter int WIDTH_P = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  output logic [WIDTH_P-1:0] count_o
);

  logic [WIDTH_P-1:0] count_q;
  logic [WIDTH_P-1:0] count_d;

  // Next count: advance by one on each up pulse, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (up_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register; clear has priority over counting.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/chart_recorder.sv
// Records debounced pad presses, quantised to beat ticks, as chart entries in RAM.
module chart_recorder
  import ddr_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                beat_i,
  input  logic [ARROW_W-1:0]  buttons_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [ENTRY_W-1:0]  wr_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          entries_o
);

  state_t               state_q, state_d;
  logic [ARROW_W-1:0]   mask_q, mask_d;
  logic [TIMING_W-1:0]  gap_q, gap_d;
  logic [ARROW_W-1:0]   btn_prev_q, btn_prev_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [ENTRY_W-1:0]   wr_data_q, wr_data_d;
  logic [7:0]           entries_q, entries_d;

  logic [ARROW_W-1:0]   rise;
  logic [ARROW_W-1:0]   mask_now;
  logic [TIMING_W-1:0]  gap_next;
  logic                 write_now;
  logic                 clear_addr;
  logic                 addr_reset;
  logic [ADDR_W-1:0]    addr;

  // Current write address; cleared by reset or by starting a new recording.
  assign addr_reset = reset_i | clear_addr;

  counter_up #(
    .WIDTH_P(ADDR_W)
  ) u_addr (
    .clk_i  (clk_i),
    .reset_i(addr_reset),
    .up_i   (write_now),
    .count_o(addr)
  );

  // Next-state and next-output logic for the recording FSM.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    gap_d      = gap_q;
    btn_prev_d = buttons_i;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    entries_d  = entries_q;
    write_now  = 1'b0;
    clear_addr = 1'b0;

    rise     = buttons_i & ~btn_prev_q;
    mask_now = mask_q | rise;
    gap_next = gap_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = REC;
          mask_d     = '0;
          gap_d      = '0;
          entries_d  = '0;
          clear_addr = 1'b1;
        end
      end
      REC: begin
        mask_d = mask_now;
        if (beat_i) begin
          if ((mask_now != '0) || (gap_next == TIMING_MAX)) begin
            write_now = 1'b1;
            wr_data_d = pack_entry(mask_now, gap_next);
            mask_d    = '0;
            gap_d     = '0;
            if (addr == LAST_DATA_ADDR) begin
              state_d = TERM;
            end
          end else begin
            gap_d = gap_next;
          end
        end
        if (stop_i) begin
          state_d = TERM;
          mask_d  = '0;
          gap_d   = '0;
        end
      end
      TERM: begin
        write_now = 1'b1;
        wr_data_d = TERMINATOR;
        state_d   = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (write_now) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr;
      entries_d = entries_q + 8'd1;
    end
  end

  // State and registered outputs; reset drops any write being presented.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      gap_q      <= '0;
      btn_prev_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      entries_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      gap_q      <= gap_d;
      btn_prev_q <= btn_prev_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      entries_q  <= entries_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q == REC) || (state_q == TERM);
  assign done_o    = (state_q == DONE);
  assign entries_o = entries_q;

endmodule
